// File: rtl/alu4_pkg.sv
// Shared constants for the 4-bit ALU issue path: data widths, operation
// selects, compare result codes and the sequencer FSM state encoding.
package alu4_pkg;

    localparam int ALU4_WIDTH = 4;
    localparam int ALU4_SEL_W = 3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_CMP = 3'b111;

    // Produced by the ALU itself; the sequencer only carries them through.
    localparam logic [3:0] CMP_EQ = 4'b0010;
    localparam logic [3:0] CMP_GT = 4'b0001;
    localparam logic [3:0] CMP_LT = 4'b0000;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EXEC = 2'b01;
    localparam logic [1:0] ST_RESP = 2'b10;

endpackage

// File: rtl/alu4_op_sequencer.sv
// Issue stage for the 4-bit ALU: request handshake -> registered ALU inputs ->
// captured result -> response handshake. Optional macro: ALU4_ACC_FWD_EN.
module alu4_op_sequencer
    import alu4_pkg::*;
#(
    parameter int WIDTH = alu4_pkg::ALU4_WIDTH,
    parameter int SEL_W = alu4_pkg::ALU4_SEL_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [SEL_W-1:0] in_sel,
`ifdef ALU4_ACC_FWD_EN
    input  logic             in_use_acc,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_c,
    output logic [SEL_W-1:0] out_sel,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    logic [1:0]       state_q,     state_d;
    logic [WIDTH-1:0] alu_a_q,     alu_a_d;
    logic [WIDTH-1:0] alu_b_q,     alu_b_d;
    logic [SEL_W-1:0] alu_sel_q,   alu_sel_d;
    logic [WIDTH-1:0] out_c_q,     out_c_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] a_src_s;
    logic             resp_hs_s;

    assign resp_hs_s = (state_q == ST_RESP) && out_ready;

`ifdef ALU4_ACC_FWD_EN
    logic [WIDTH-1:0] acc_q, acc_d;

    assign a_src_s = in_use_acc ? acc_q : in_a;

    // Accumulator follows each completed response.
    always_comb begin
        acc_d = acc_q;
        if (resp_hs_s) begin
            acc_d = out_c_q;
        end else begin
            acc_d = acc_q;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    assign a_src_s = in_a;
`endif

    // FSM next-state and datapath load decisions.
    always_comb begin
        state_d     = state_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_sel_d   = alu_sel_q;
        out_c_d     = out_c_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        cnt_d       = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    alu_a_d   = a_src_s;
                    alu_b_d   = in_b;
                    alu_sel_d = in_sel;
                    state_d   = ST_EXEC;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_EXEC: begin
                out_c_d     = alu_c;
                out_sel_d   = alu_sel_q;
                out_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d     = ST_IDLE;
                end else begin
                    state_d     = ST_RESP;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_sel_q   <= '0;
            out_c_q     <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_sel_q   <= alu_sel_d;
            out_c_q     <= out_c_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign out_c     = out_c_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;
    assign op_count  = cnt_q;

endmodule
